// File: rtl/ifid_fetch_queue.sv
// Instruction fetch unit with a DEPTH-entry prefetch queue between imem and decode.
// One request is outstanding at a time; a redirect flushes the queue and restarts fetch.
module ifid_fetch_queue #(
    parameter int               XLEN     = 32,
    parameter int               DEPTH    = 4,
    parameter logic [XLEN-1:0]  RESET_PC = '0
) (
    input  logic                       clk,
    input  logic                       rst,
    output logic                       imem_req,
    output logic [XLEN-1:0]            imem_addr,
    input  logic                       imem_ack,
    input  logic [31:0]                imem_data,
    input  logic                       redirect,
    input  logic [XLEN-1:0]            redirect_pc,
    output logic                       id_valid,
    input  logic                       id_ready,
    output logic [XLEN-1:0]            id_pc,
    output logic [31:0]                id_instruction,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH+1);

    logic [XLEN-1:0]  r_fetch_pc;
    logic             r_req;
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;
    logic [XLEN-1:0]  r_pc_mem    [DEPTH];
    logic [31:0]      r_instr_mem [DEPTH];

    logic             w_push;
    logic             w_pop;
    logic             w_valid;
    logic [CNT_W-1:0] w_count_next;

    assign w_valid = (r_count != '0);
    assign w_push  = imem_ack & r_req & ~redirect;
    assign w_pop   = w_valid & id_ready & ~redirect;

    always_comb begin
        // NOTE: default assignment first so no path leaves the signal unassigned (no latch).
        w_count_next = r_count;
        case ({w_push, w_pop})
            2'b10:   w_count_next = r_count + CNT_W'(1);
            2'b01:   w_count_next = r_count - CNT_W'(1);
            default: w_count_next = r_count;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_req      <= 1'b0;
            r_fetch_pc <= RESET_PC & ~XLEN'(3);
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
        end else if (redirect) begin
            r_req      <= 1'b1;
            r_fetch_pc <= redirect_pc & ~XLEN'(3);
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr   <= r_wr_ptr + PTR_W'(1);
                r_fetch_pc <= r_fetch_pc + XLEN'(4);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            r_count <= w_count_next;
            r_req   <= (w_count_next < CNT_W'(DEPTH));
        end
    end

    // NOTE: queue storage is not reset; outputs are gated by id_valid so stale entries never leak.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_pc_mem[r_wr_ptr]    <= r_fetch_pc;
            r_instr_mem[r_wr_ptr] <= imem_data;
        end
    end

    assign imem_req       = r_req;
    assign imem_addr      = r_fetch_pc;
    assign id_valid       = w_valid;
    assign id_pc          = w_valid ? r_pc_mem[r_rd_ptr]    : '0;
    assign id_instruction = w_valid ? r_instr_mem[r_rd_ptr] : '0;
    assign count          = r_count;

endmodule

// File: doc/ifid_fetch_queue.md
# ifid_fetch_queue

Parametrised instruction fetch unit and prefetch queue sitting between instruction memory and the decode stage. It generates sequential fetch addresses and holds one outstanding memory request. Returned {pc, instruction} pairs are buffered in a DEPTH-entry FIFO and presented to decode through a valid/ready handshake. A redirect from the branch/exception logic flushes the queue and restarts fetch at a new PC.

## Interface
Parameters:
- XLEN, 32, width of PC and addresses
- DEPTH, 4, queue entries; power of two, ≥ 2
- RESET_PC, 32'h0000_0000, first fetch address after reset

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-high reset
- imem_req  out  1  fetch request pending (registered)
- imem_addr  out  XLEN  fetch address; bits [1:0] always 0
- imem_ack  in  1  memory returns imem_data for the current imem_addr this cycle; ignored unless imem_req=1
- imem_data  in  32  instruction word
- redirect  in  1  flush and restart fetch
- redirect_pc  in  XLEN  restart address; bits [1:0] forced to 0
- id_valid  out  1  head entry valid
- id_ready  in  1  decode accepts head entry
- id_pc  out  XLEN  PC of head entry
- id_instruction  out  32  instruction of head entry
- count  out  $clog2(DEPTH+1)  occupied entries

## Operation
- State: fetch_pc (drives imem_addr), req_r (drives imem_req), storage[DEPTH], wr_ptr, rd_ptr, count. Pointers wrap modulo DEPTH.
- Reset (async): imem_req=0, imem_addr=RESET_PC, count=0, id_valid=0, pointers=0. id_pc and id_instruction read as 0.
- push = imem_ack & imem_req & ~redirect. A push writes {fetch_pc, imem_data} at wr_ptr and sets fetch_pc += 4, wrapping mod 2^XLEN.
- pop = id_valid & id_ready & ~redirect. A pop advances rd_ptr.
- count_next = count + push − pop. Push and pop in the same cycle leave count unchanged.
- req_r next = (count_next < DEPTH). A request is re-issued every cycle while there is space. Because at most one request is ever outstanding, a push can never overflow the queue.
- While imem_req=1 and no ack arrives, imem_addr holds stable. It changes only on a push or a redirect.
- id_valid = (count ≠ 0). id_pc and id_instruction come combinationally from storage[rd_ptr].
- Redirect has priority over everything:
  - count, wr_ptr and rd_ptr return to 0.
  - fetch_pc = redirect_pc & ~3.
  - req_r = 1.
  - An ack in the same cycle is discarded. id_ready in the same cycle is ignored.
- Values on id_pc and id_instruction while id_valid=0 are don't-care.

## Timing
- First posedge after rst release: imem_req goes 1 with imem_addr=RESET_PC.
- Memory with ack in the request cycle gives one instruction per cycle. Request at cycle N with ack at N puts the entry on id_valid at N+1.
- Redirect asserted at cycle N: from N+1, id_valid=0, count=0, imem_req=1, imem_addr=redirect_pc&~3. The first redirected instruction is visible no earlier than N+2.
- Full queue (count=DEPTH): imem_req=0 from the next edge. A pop at count=DEPTH re-asserts imem_req on the following edge.
- rst asserted mid-stream: all outputs return to reset values immediately, without waiting for a clock edge. In-flight acks are lost.

## Test plan
- Reset: hold rst for 2 cycles, then release → imem_req=0, count=0, id_valid=0 during reset. At the first edge after release, imem_req=1 and imem_addr=0x0.
- Streaming: ack every cycle with data 0x00000013+k, id_ready=1 → id_pc sequence 0x0, 0x4, 0x8, 0xC with matching instructions; count stays ≤1 and id_valid stays high continuously.
- Fill/backpressure: id_ready=0, ack every cycle → count reaches 4 and imem_req drops to 0 with imem_addr=0x10. Raise id_ready for one cycle → count=3, then imem_req=1 at the next edge.
- Simultaneous push/pop: count=2, ack and id_ready both high → count stays 2, and the head advances by exactly one entry.
- Redirect with ack in the same cycle: count=3, redirect=1, redirect_pc=0x1002, imem_ack=1 → next cycle count=0, id_valid=0, imem_addr=0x1000, and the acked word never appears on id_instruction.
- Async reset mid-operation: assert rst between edges with count=3 → count=0, id_valid=0, imem_req=0 immediately. Fetch restarts at RESET_PC after release.
